// File: rtl/rsp_test_tone_gen_pkg.sv
// Shared constants for the stepped-sine test source: quantized tone tables,
// sequencer state encodings and tone_sel codes.
package rsp_test_tone_gen_pkg;

    localparam int TONE_W = 16;

    // 8-step sine table; -32768 is the raw 16-bit minimum, not a negated 32767
    localparam logic signed [TONE_W-1:0] SIN8_0 = 16'sd0;
    localparam logic signed [TONE_W-1:0] SIN8_1 = 16'sd23170;
    localparam logic signed [TONE_W-1:0] SIN8_2 = 16'sd32767;
    localparam logic signed [TONE_W-1:0] SIN8_3 = 16'sd23170;
    localparam logic signed [TONE_W-1:0] SIN8_4 = 16'sd0;
    localparam logic signed [TONE_W-1:0] SIN8_5 = 16'(-23170);
    localparam logic signed [TONE_W-1:0] SIN8_6 = 16'h8000;
    localparam logic signed [TONE_W-1:0] SIN8_7 = 16'(-23170);

    localparam logic signed [TONE_W-1:0] SQ4_0 = 16'sd0;
    localparam logic signed [TONE_W-1:0] SQ4_1 = 16'sd32767;
    localparam logic signed [TONE_W-1:0] SQ4_2 = 16'sd0;
    localparam logic signed [TONE_W-1:0] SQ4_3 = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_TONE_A = 3'd2,
        ST_TONE_B = 3'd3,
        ST_TONE_C = 3'd4
    } seq_state_e;

    localparam logic [1:0] SEL_IDLE = 2'd0;
    localparam logic [1:0] SEL_A    = 2'd1;
    localparam logic [1:0] SEL_B    = 2'd2;
    localparam logic [1:0] SEL_C    = 2'd3;

    function automatic logic [TONE_W-1:0] tone_lookup(input logic is8, input logic [2:0] idx);
        logic [TONE_W-1:0] v;
        v = '0;
        if (is8) begin
            case (idx)
                3'd0: v = SIN8_0;
                3'd1: v = SIN8_1;
                3'd2: v = SIN8_2;
                3'd3: v = SIN8_3;
                3'd4: v = SIN8_4;
                3'd5: v = SIN8_5;
                3'd6: v = SIN8_6;
                default: v = SIN8_7;
            endcase
        end else begin
            case (idx[1:0])
                2'd0: v = SQ4_0;
                2'd1: v = SQ4_1;
                2'd2: v = SQ4_2;
                default: v = SQ4_3;
            endcase
        end
        return v;
    endfunction

endpackage

// File: rtl/rsp_test_tone_gen_step_tone.sv
// Free-running step generator: advances its table index every hold+1 cycles
// and presents the quantized tone value for the current step.
module rsp_step_tone
    import rsp_test_tone_gen_pkg::*;
#(
    parameter int NSTEPS = 8,
    parameter int HOLD_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [HOLD_W-1:0] hold,
    output logic [TONE_W-1:0] value
);
    localparam int STEP_W = $clog2(NSTEPS);

    logic [STEP_W-1:0] step_q, step_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    // >= (not ==) so a hold lowered below the running count advances at once
    always_comb begin
        step_d = step_q;
        cnt_d  = cnt_q;
        if (restart) begin
            step_d = '0;
            cnt_d  = '0;
        end else if (cnt_q >= hold) begin
            cnt_d  = '0;
            step_d = step_q + STEP_W'(1);
        end else begin
            cnt_d  = cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= '0;
            cnt_q  <= '0;
        end else begin
            step_q <= step_d;
            cnt_q  <= cnt_d;
        end
    end

    assign value = tone_lookup(NSTEPS == 8, 3'(step_q));

endmodule

// File: rtl/rsp_test_tone_gen.sv
// Stepped-sine stimulus source: after start plays settle, tone A, tone B,
// then tone C forever, driving a registered signed sample stream.
module rsp_test_tone_gen
    import rsp_test_tone_gen_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int HOLD_W   = 10,
    parameter int SEQ_W    = 13,
    parameter int SEG0_END = 15,
    parameter int SEG1_END = 990,
    parameter int SEG2_END = 1500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_a,
    input  logic [HOLD_W-1:0] hold_b,
    input  logic [HOLD_W-1:0] hold_c,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic [1:0]        tone_sel,
    output logic              busy
);
    localparam logic [SEQ_W-1:0] SEQ_MAX = '1;

    logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
    seq_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              vld_q, vld_d;
    logic [1:0]        sel_q, sel_d;
    logic [TONE_W-1:0] val_a, val_b, val_c;

    rsp_step_tone #(.NSTEPS(8), .HOLD_W(HOLD_W)) u_tone_a (
        .clk(clk), .reset(reset), .restart(start), .hold(hold_a), .value(val_a));
    rsp_step_tone #(.NSTEPS(8), .HOLD_W(HOLD_W)) u_tone_b (
        .clk(clk), .reset(reset), .restart(start), .hold(hold_b), .value(val_b));
    rsp_step_tone #(.NSTEPS(4), .HOLD_W(HOLD_W)) u_tone_c (
        .clk(clk), .reset(reset), .restart(start), .hold(hold_c), .value(val_c));

    function automatic seq_state_e seg_decode(input logic [SEQ_W-1:0] cnt);
        if (cnt < SEQ_W'(SEG0_END))      return ST_SETTLE;
        else if (cnt < SEQ_W'(SEG1_END)) return ST_TONE_A;
        else if (cnt < SEQ_W'(SEG2_END)) return ST_TONE_B;
        else                             return ST_TONE_C;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_cnt_q <= '0;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            out_q     <= '0;
            vld_q     <= 1'b0;
            sel_q     <= SEL_IDLE;
        end else begin
            seq_cnt_q <= seq_cnt_d;
            state_q   <= state_d;
            busy_q    <= busy_d;
            out_q     <= out_d;
            vld_q     <= vld_d;
            sel_q     <= sel_d;
        end
    end

    // Schedule counter saturates so TONE_C can never fall back to SETTLE
    always_comb begin
        seq_cnt_d = seq_cnt_q;
        busy_d    = busy_q;
        state_d   = state_q;
        if (start) begin
            seq_cnt_d = '0;
            busy_d    = 1'b1;
            state_d   = ST_SETTLE;
        end else if (state_q != ST_IDLE) begin
            if (seq_cnt_q != SEQ_MAX) seq_cnt_d = seq_cnt_q + SEQ_W'(1);
            state_d = seg_decode(seq_cnt_d);
        end
    end

    // A restart forces settle values on its own edge rather than one late sample
    always_comb begin
        out_d = '0;
        vld_d = 1'b0;
        sel_d = SEL_IDLE;
        if (!start) begin
            case (state_q)
                ST_TONE_A: begin out_d = DATA_W'($signed(val_a)); vld_d = 1'b1; sel_d = SEL_A; end
                ST_TONE_B: begin out_d = DATA_W'($signed(val_b)); vld_d = 1'b1; sel_d = SEL_B; end
                ST_TONE_C: begin out_d = DATA_W'($signed(val_c)); vld_d = 1'b1; sel_d = SEL_C; end
                default: ;
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;
    assign tone_sel  = sel_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rsp_test_tone_gen.sv
// Randomized self-checking bench for rsp_test_tone_gen against a cycle-count
// reference model built from the schedule and step-duration rules.
module tb_rsp_test_tone_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  hold_a = '0, hold_b = '0, hold_c = '0;
    logic [15:0] out;
    logic        out_valid;
    logic [1:0]  tone_sel;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    int SIN8[8] = '{0, 23170, 32767, 23170, 0, -23170, -32768, -23170};
    int SQ4[4]  = '{0, 32767, 0, -32768};

    // model state: cycles since start (t), saturating schedule count, per-tone step/count
    bit          m_busy;
    int          m_k, t;
    int          m_cnt[3], m_step[3];
    logic [15:0] e_out;
    bit          e_vld;
    logic [1:0]  e_sel;

    rsp_test_tone_gen dut (
        .clk(clk), .reset(reset), .start(start), .hold_a(hold_a), .hold_b(hold_b),
        .hold_c(hold_c), .out(out), .out_valid(out_valid), .tone_sel(tone_sel), .busy(busy));

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_k = 0; t = 0;
        e_out = '0; e_vld = 0; e_sel = '0;
        for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_step[i] = 0; end
    endtask

    task automatic model_edge();
        int seg, h, n;
        if (reset) begin model_reset(); return; end
        if (start) begin
            model_reset();
            m_busy = 1;
            return;
        end
        seg = !m_busy ? 0 : (m_k < 15) ? 0 : (m_k < 990) ? 1 : (m_k < 1500) ? 2 : 3;
        e_sel = 2'(seg);
        e_vld = (seg != 0);
        e_out = (seg == 0) ? 16'd0 : (seg == 3) ? 16'(SQ4[m_step[2]]) : 16'(SIN8[m_step[seg-1]]);
        if (m_busy && m_k < 8191) m_k++;
        for (int i = 0; i < 3; i++) begin
            h = (i == 0) ? int'(hold_a) : (i == 1) ? int'(hold_b) : int'(hold_c);
            n = (i == 2) ? 4 : 8;
            if (m_cnt[i] >= h) begin m_cnt[i] = 0; m_step[i] = (m_step[i] + 1) % n; end
            else m_cnt[i]++;
        end
        t++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 110; i++) begin
            cyc();
            vectors++;
            if (out !== 16'd0 || out_valid !== 1'b0 || tone_sel !== 2'd0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d out=%0d vld=%b sel=%0d busy=%b want all 0", i, out, out_valid, tone_sel, busy);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if (out !== e_out || out_valid !== e_vld || tone_sel !== e_sel || busy !== m_busy) begin
                miscompares++;
                $display("FAIL idle_no_start out=%0d vld=%b sel=%0d busy=%b want 0/0/0/0", out, out_valid, tone_sel, busy);
            end
        end
    endtask

    task automatic test_schedule();
        int want;
        hold_a = 10'd24; hold_b = 10'd9; hold_c = 10'd0;
        do_start();
        vectors++;
        if (out !== 16'd0 || tone_sel !== 2'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_edge out=%0d sel=%0d busy=%b want 0/0/1", out, tone_sel, busy);
        end
        while (t < 1600) begin
            cyc();
            vectors++;
            if (out !== e_out || out_valid !== e_vld || tone_sel !== e_sel || busy !== m_busy) begin
                miscompares++;
                $display("FAIL sched t=%0d out=%0d/%0d vld=%b/%b sel=%0d/%0d busy=%b/%b",
                         t, out, e_out, out_valid, e_vld, tone_sel, e_sel, busy, m_busy);
            end
            // closed-form expectation for fixed holds: value at t reflects the step after edge t-1
            if (t <= 15)        want = 0;
            else if (t <= 990)  want = SIN8[((t - 1) / 25) % 8];
            else if (t <= 1500) want = SIN8[((t - 1) / 10) % 8];
            else                want = SQ4[(t - 1) % 4];
            vectors++;
            if (out !== 16'(want) || tone_sel !== 2'((t <= 15) ? 0 : (t <= 990) ? 1 : (t <= 1500) ? 2 : 3)) begin
                miscompares++;
                $display("FAIL sched_closed t=%0d out=%0d want %0d sel=%0d", t, $signed(out), want, tone_sel);
            end
        end
    endtask

    task automatic test_restart_in_c();
        int wait_n = $urandom_range(0, 20);
        for (int i = 0; i < wait_n; i++) cyc();
        do_start();
        vectors++;
        if (out !== 16'd0 || tone_sel !== 2'd0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_c out=%0d sel=%0d vld=%b busy=%b want 0/0/0/1", out, tone_sel, out_valid, busy);
        end
        while (t < 40) begin
            cyc();
            vectors++;
            if (out !== e_out || out_valid !== e_vld || tone_sel !== e_sel || busy !== m_busy) begin
                miscompares++;
                $display("FAIL restart_run t=%0d out=%0d/%0d sel=%0d/%0d", t, out, e_out, tone_sel, e_sel);
            end
            if (t == 15 || t == 16) begin
                vectors++;
                if (tone_sel !== 2'(t == 16 ? 1 : 0) || out !== 16'd0) begin
                    miscompares++;
                    $display("FAIL restart_resume t=%0d sel=%0d out=%0d", t, tone_sel, out);
                end
            end
        end
    endtask

    task automatic test_hold_change();
        hold_a = 10'd24;
        do_start();
        while (t < 10) cyc();
        hold_a = 10'd3;
        while (t < 30) begin
            cyc();
            vectors++;
            if (out !== e_out || out_valid !== e_vld || tone_sel !== e_sel || busy !== m_busy) begin
                miscompares++;
                $display("FAIL hold_chg t=%0d out=%0d/%0d sel=%0d/%0d", t, out, e_out, tone_sel, e_sel);
            end
            if (t == 16 || t == 19 || t == 20) begin
                vectors++;
                if (out !== 16'(t == 20 ? 23170 : 32767)) begin
                    miscompares++;
                    $display("FAIL hold_chg_fixed t=%0d out=%0d want %0d", t, out, (t == 20) ? 23170 : 32767);
                end
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 6; it++) begin
            hold_a = 10'($urandom_range(0, 15));
            hold_b = 10'($urandom_range(0, 15));
            hold_c = 10'($urandom_range(0, 7));
            do_start();
            len = $urandom_range(20, 1700);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 49) == 0) hold_a = 10'($urandom_range(0, 30));
                if ($urandom_range(0, 49) == 0) hold_b = 10'($urandom_range(0, 30));
                if ($urandom_range(0, 49) == 0) hold_c = 10'($urandom_range(0, 5));
                start = ($urandom_range(0, 599) == 0);
                cyc();
                start = 1'b0;
                vectors++;
                if (out !== e_out || out_valid !== e_vld || tone_sel !== e_sel || busy !== m_busy) begin
                    miscompares++;
                    $display("FAIL random it=%0d t=%0d out=%0d/%0d vld=%b/%b sel=%0d/%0d",
                             it, t, out, e_out, out_valid, e_vld, tone_sel, e_sel);
                end
            end
        end
    endtask

    task automatic test_saturate();
        hold_a = 10'd5; hold_b = 10'd7; hold_c = 10'($urandom_range(0, 3));
        do_start();
        for (int i = 0; i < 10000; i++) begin
            cyc();
            vectors++;
            if (out !== e_out || out_valid !== e_vld || tone_sel !== e_sel || busy !== m_busy ||
                (t > 1500 && tone_sel !== 2'd3)) begin
                miscompares++;
                $display("FAIL saturate t=%0d out=%0d/%0d sel=%0d/%0d", t, out, e_out, tone_sel, e_sel);
            end
        end
    endtask

    task automatic test_reset_mid();
        hold_b = 10'd9;
        do_start();
        while (t < 1200) cyc();
        vectors++;
        if (tone_sel !== 2'd2 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_b sel=%0d vld=%b want 2/1", tone_sel, out_valid);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (out !== 16'd0 || out_valid !== 1'b0 || tone_sel !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async out=%0d vld=%b sel=%0d busy=%b want all 0", out, out_valid, tone_sel, busy);
        end
        model_reset();
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if (out !== e_out || out_valid !== e_vld || tone_sel !== e_sel || busy !== m_busy) begin
                miscompares++;
                $display("FAIL post_reset_idle out=%0d sel=%0d busy=%b", out, tone_sel, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_schedule();
        test_restart_in_c();
        test_hold_change();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
